// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioner.
// Holds the repeat-FSM state encoding and the counter sizing helper.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } rpt_state_t;

    // Defaults assume a 100 MHz system clock.
    localparam int DEF_DB_CYCLES  = 1_000_000;
    localparam int DEF_RPT_DELAY  = 40_000_000;
    localparam int DEF_RPT_PERIOD = 10_000_000;

    function automatic int ctr_width(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: two-flop synchronizer, debounce counter,
// registered press/release pulses and the auto-repeat FSM.
module btn_channel
    import btn_pkg::*;
#(
    parameter int DB_CYCLES  = DEF_DB_CYCLES,
    parameter int RPT_DELAY  = DEF_RPT_DELAY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int W = ctr_width(DB_CYCLES, RPT_DELAY, RPT_PERIOD);
    localparam logic [W-1:0] DB_LAST  = W'(DB_CYCLES - 1);
    localparam logic [W-1:0] RD_LAST  = W'(RPT_DELAY - 1);
    localparam logic [W-1:0] RP_LAST  = W'(RPT_PERIOD - 1);

    logic         sync1_reg;
    logic         sync2_reg;
    logic         level_reg;
    logic         press_reg;
    logic         release_reg;
    logic         repeat_reg;
    logic         repeat_next;
    logic [W-1:0] cnt_reg;
    logic [W-1:0] rcnt_reg;
    logic [W-1:0] rcnt_next;
    rpt_state_t   state_reg;
    rpt_state_t   state_next;
    logic         accept;
    logic         accept_rise;
    logic         accept_fall;

    // A change is accepted on the edge where the count reaches its terminal value.
    assign accept      = (sync2_reg != level_reg) && (cnt_reg == DB_LAST);
    assign accept_rise = accept && sync2_reg;
    assign accept_fall = accept && !sync2_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_reg   <= 1'b0;
            sync2_reg   <= 1'b0;
            level_reg   <= 1'b0;
            cnt_reg     <= '0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
        end else begin
            sync1_reg   <= btn_in;
            sync2_reg   <= sync1_reg;
            press_reg   <= accept_rise;
            release_reg <= accept_fall;
            if (sync2_reg == level_reg) begin
                cnt_reg <= '0;
            end else if (cnt_reg == DB_LAST) begin
                level_reg <= sync2_reg;
                cnt_reg   <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg  <= IDLE;
            rcnt_reg   <= '0;
            repeat_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            rcnt_reg   <= rcnt_next;
            repeat_reg <= repeat_next;
        end
    end

    // A release always takes priority over a repeat falling due on the same edge.
    always_comb begin
        state_next  = state_reg;
        rcnt_next   = rcnt_reg;
        repeat_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (accept_rise) begin
                    state_next  = DELAY;
                    rcnt_next   = '0;
                    repeat_next = 1'b1;
                end
            end
            DELAY: begin
                if (accept_fall) begin
                    state_next = IDLE;
                    rcnt_next  = '0;
                end else if (rcnt_reg == RD_LAST) begin
                    state_next  = REPEAT;
                    rcnt_next   = '0;
                    repeat_next = 1'b1;
                end else begin
                    rcnt_next = rcnt_reg + 1'b1;
                end
            end
            REPEAT: begin
                if (accept_fall) begin
                    state_next = IDLE;
                    rcnt_next  = '0;
                end else if (rcnt_reg == RP_LAST) begin
                    rcnt_next   = '0;
                    repeat_next = 1'b1;
                end else begin
                    rcnt_next = rcnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                rcnt_next  = '0;
            end
        endcase
    end

    assign btn_level   = level_reg;
    assign btn_press   = press_reg;
    assign btn_release = release_reg;
    assign btn_repeat  = repeat_reg;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button front end: N_BTN independent conditioned channels
// assembled onto level/press/release/repeat buses.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN      = 3,
    parameter int DB_CYCLES  = DEF_DB_CYCLES,
    parameter int RPT_DELAY  = DEF_RPT_DELAY,
    parameter int RPT_PERIOD = DEF_RPT_PERIOD
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_in,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_BTN-1:0] btn_repeat
);

    generate
        for (genvar gi = 0; gi < N_BTN; gi++) begin : g_ch
            btn_channel #(
                .DB_CYCLES (DB_CYCLES),
                .RPT_DELAY (RPT_DELAY),
                .RPT_PERIOD(RPT_PERIOD)
            ) u_ch (
                .clk        (clk),
                .reset      (reset),
                .btn_in     (btn_in[gi]),
                .btn_level  (btn_level[gi]),
                .btn_press  (btn_press[gi]),
                .btn_release(btn_release[gi]),
                .btn_repeat (btn_repeat[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: expected pulse events are queued from pin-edge
// timing when stimulus is driven and matched against the outputs each cycle.
module tb_btn_conditioner;

    localparam int N   = 3;
    localparam int DB  = 4;
    localparam int RD  = 20;
    localparam int RP  = 8;
    localparam int LAT = DB + 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] btn = '0;
    logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        int cyc;
        int ch;
        int kind;   // 0 press, 1 release, 2 repeat
    } ev_t;

    ev_t          exp_q[$];
    logic [N-1:0] lvl_exp = '0;
    int           rpt_count[N];

    typedef struct {
        int ch;
        int hold;
        int exp_repeats;
    } vec_t;

    vec_t vecs[8];

    btn_conditioner #(
        .N_BTN     (N),
        .DB_CYCLES (DB),
        .RPT_DELAY (RD),
        .RPT_PERIOD(RP)
    ) dut (
        .clk        (clk),
        .reset      (rst_n),
        .btn_in     (btn),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int c = 0; c < N; c++) rpt_count[c] = 0;
    end

    function automatic string kname(input int k);
        case (k)
            0:       return "press";
            1:       return "release";
            default: return "repeat";
        endcase
    endfunction

    // Scoreboard monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            lvl_exp = '0;
            exp_q.delete();
        end else begin
            for (int c = 0; c < N; c++) begin
                for (int k = 0; k < 3; k++) begin
                    int   idx;
                    logic obs;
                    obs = (k == 0) ? btn_press[c] : (k == 1) ? btn_release[c] : btn_repeat[c];
                    idx = -1;
                    for (int i = 0; i < exp_q.size(); i++)
                        if (exp_q[i].cyc == cyc && exp_q[i].ch == c && exp_q[i].kind == k) idx = i;
                    if (idx >= 0 || obs) begin
                        checks++;
                        if ((idx >= 0) != obs) begin
                            errors++;
                            $display("FAIL %s ch%0d cycle %0d: got %0b want %0b",
                                     kname(k), c, cyc, obs, (idx >= 0));
                        end
                    end
                    if (idx >= 0) begin
                        if (k == 0) lvl_exp[c] = 1'b1;
                        if (k == 1) lvl_exp[c] = 1'b0;
                        exp_q.delete(idx);
                    end
                    if (obs && k == 2) rpt_count[c]++;
                end
                checks++;
                if (btn_level[c] !== lvl_exp[c]) begin
                    errors++;
                    $display("FAIL level ch%0d cycle %0d: got %0b want %0b",
                             c, cyc, btn_level[c], lvl_exp[c]);
                end
            end
        end
    end

    // Pin (or reset release) edge at cycle p, pin dropped h cycles later.
    task automatic push_hold(input int ch, input int p, input int h, input bit rel);
        int o;
        exp_q.push_back('{p + LAT, ch, 0});
        exp_q.push_back('{p + LAT, ch, 2});
        o = RD;
        while (o < h) begin
            exp_q.push_back('{p + LAT + o, ch, 2});
            o += RP;
        end
        if (rel) exp_q.push_back('{p + LAT + h, ch, 1});
    endtask

    task automatic play(input int row, input int ch, input int hold, input int exp_rpt);
        int p;
        int base;
        base = rpt_count[ch];
        @(negedge clk);
        btn[ch] = 1'b1;
        p = cyc;
        push_hold(ch, p, hold, 1'b1);
        repeat (hold) @(negedge clk);
        btn[ch] = 1'b0;
        repeat (12) @(negedge clk);
        checks++;
        if (rpt_count[ch] - base != exp_rpt) begin
            errors++;
            $display("FAIL row%0d repeat count ch%0d: got %0d want %0d",
                     row, ch, rpt_count[ch] - base, exp_rpt);
        end
        $display("row %0d: ch%0d hold %0d -> %0d repeat pulses", row, ch, hold, rpt_count[ch] - base);
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({btn_level, btn_press, btn_release, btn_repeat} !== '0) begin
            errors++;
            $display("FAIL %s: got %b want all zero", tag,
                     {btn_level, btn_press, btn_release, btn_repeat});
        end
    endtask

    initial begin
        int p;
        vecs[0] = '{0, 10, 1};   // clean press
        vecs[1] = '{0, 60, 6};   // hold: 0,20,28,36,44,52
        vecs[2] = '{0, 28, 2};   // release lands on repeat offset 28
        vecs[3] = '{0, 20, 1};   // release lands on first repeat offset
        vecs[4] = '{0, 21, 2};
        vecs[5] = '{1, 36, 3};
        vecs[6] = '{2, DB, 1};   // minimum accepted pulse width
        vecs[7] = '{1, 5, 1};

        repeat (3) @(negedge clk);
        check_all_zero("reset state");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("idle after reset");

        for (int i = 0; i < 8; i++) play(i, vecs[i].ch, vecs[i].hold, vecs[i].exp_repeats);

        // Bounce: toggle every 2 cycles, then settle high.
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            btn[0] = (k % 2 == 0);
            repeat (2) @(negedge clk);
        end
        btn[0] = 1'b1;
        p = cyc;
        push_hold(0, p, 10, 1'b1);
        repeat (10) @(negedge clk);
        btn[0] = 1'b0;
        repeat (12) @(negedge clk);
        $display("bounce: single press expected at cycle %0d", p + LAT);

        // Reset in the middle of REPEAT with the pin still held.
        @(negedge clk);
        btn[0] = 1'b1;
        p = cyc;
        push_hold(0, p, 1000, 1'b0);
        repeat (40) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_all_zero("async reset clear");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        p = cyc;
        push_hold(0, p, 15, 1'b1);
        repeat (15) @(negedge clk);
        btn[0] = 1'b0;
        repeat (12) @(negedge clk);
        $display("reset mid-hold: re-press expected at cycle %0d", p + LAT);

        // Two channels pressed together, released 20 cycles apart.
        @(negedge clk);
        btn[1] = 1'b1;
        btn[2] = 1'b1;
        p = cyc;
        push_hold(1, p, 10, 1'b1);
        push_hold(2, p, 30, 1'b1);
        repeat (10) @(negedge clk);
        btn[1] = 1'b0;
        repeat (20) @(negedge clk);
        btn[2] = 1'b0;
        repeat (12) @(negedge clk);
        $display("two channels: releases expected at cycles %0d and %0d", p + LAT + 10, p + LAT + 30);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d pending events want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
